// File: rtl/inst_fetcher.sv
// Instruction fetcher: fetch PC plus a direct-mapped, one-word-per-line I-cache.
// Misses are issued as word reads to the memory controller and held until done.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        oMEM_en,
    output logic [31:0] oMEM_addr,
    input  logic        iMEM_done,
    input  logic [31:0] iMEM_inst,
    input  logic        iStall,
    input  logic        iJump_en,
    input  logic [31:0] iJump_pc,
    output logic        oInst_valid,
    output logic [31:0] oInst,
    output logic [31:0] oPC
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic {S_LOOKUP, S_WAIT} state_e;

    state_e                   state_q;
    logic [31:0]              pc_q;
    logic                     mem_en_q;
    logic [31:0]              mem_addr_q;
    logic                     inst_valid_q;
    logic [31:0]              inst_q;
    logic [31:0]              opc_q;

    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [31:0]              data_q [LINES];

    logic [ICACHE_IDX_W-1:0]  idx;
    logic [TAG_W-1:0]         tag;
    logic                     hit;
    logic [ICACHE_IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]         fill_tag;
    logic                     fill_we;

    assign idx      = pc_q[ICACHE_IDX_W+1:2];
    assign tag      = pc_q[31:ICACHE_IDX_W+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    // The fill is keyed by the latched request address, so a redirect taken
    // while waiting still caches the returned word under its own address.
    assign fill_idx = mem_addr_q[ICACHE_IDX_W+1:2];
    assign fill_tag = mem_addr_q[31:ICACHE_IDX_W+2];
    assign fill_we  = !rst && rdy && (state_q == S_WAIT) && iMEM_done;

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iMEM_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            valid_q      <= '0;
            state_q      <= S_LOOKUP;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            opc_q        <= '0;
        end else if (rdy) begin
            case (state_q)
                S_LOOKUP: begin
                    if (iJump_en) begin
                        pc_q         <= iJump_pc;
                        inst_valid_q <= 1'b0;
                    end else if (hit && !iStall) begin
                        inst_valid_q <= 1'b1;
                        inst_q       <= data_q[idx];
                        opc_q        <= pc_q;
                        pc_q         <= pc_q + 32'd4;
                    end else if (hit) begin
                        inst_valid_q <= 1'b0;
                    end else begin
                        // Stall does not hold back the miss: prefetch the current PC.
                        inst_valid_q <= 1'b0;
                        mem_en_q     <= 1'b1;
                        mem_addr_q   <= {pc_q[31:2], 2'b00};
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    inst_valid_q <= 1'b0;
                    if (iJump_en)
                        pc_q <= iJump_pc;
                    if (iMEM_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_en_q          <= 1'b0;
                        state_q           <= S_LOOKUP;
                    end
                end
                default: state_q <= S_LOOKUP;
            endcase
        end
    end

    assign oMEM_en     = mem_en_q;
    assign oMEM_addr   = mem_addr_q;
    assign oInst_valid = inst_valid_q;
    assign oInst       = inst_q;
    assign oPC         = opc_q;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: a memory responder with fixed latency, an issue
// scoreboard fed by directed phases, and explicit cycle checks at key points.
module tb_inst_fetcher;
    localparam int LAT = 5;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        iStall = 1'b0;
    logic        iJump_en = 1'b0;
    logic [31:0] iJump_pc = '0;
    logic        oMEM_en, oInst_valid;
    logic [31:0] oMEM_addr, oInst, oPC;

    logic        rsp_done = 1'b0, frc_done = 1'b0, rsp_pause = 1'b0;
    logic [31:0] rsp_inst = '0, frc_inst = '0;
    wire         iMEM_done = rsp_done | frc_done;
    wire  [31:0] iMEM_inst = frc_done ? frc_inst : rsp_inst;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } issue_t;
    issue_t      exp_q[$];
    logic [31:0] req_q[$];

    inst_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .oMEM_en(oMEM_en), .oMEM_addr(oMEM_addr),
        .iMEM_done(iMEM_done), .iMEM_inst(iMEM_inst),
        .iStall(iStall), .iJump_en(iJump_en), .iJump_pc(iJump_pc),
        .oInst_valid(oInst_valid), .oInst(oInst), .oPC(oPC)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout want event within %0d cycles", name, TMO);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic jump(input logic [31:0] pc);
        iJump_en = 1'b1;
        iJump_pc = pc;
        @(negedge clk);
        iJump_en = 1'b0;
    endtask

    task automatic wait_en(input logic [31:0] addr);
        int k = 0;
        while (oMEM_en !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) tmo("wait_req");
        else chk("req_addr_seen", oMEM_addr, addr);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (oMEM_en !== 1'b0 && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) tmo("wait_idle");
    endtask

    task automatic wait_issue(input logic [31:0] pc);
        int k = 0;
        while (!(oInst_valid === 1'b1 && oPC === pc) && k < TMO) begin @(negedge clk); k++; end
        if (k >= TMO) tmo("wait_issue");
    endtask

    // Issue scoreboard: every issued instruction must be the next expected one.
    initial begin
        issue_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && oInst_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_issue: got pc %h want no issue", oPC);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_pc", oPC, e.pc);
                    chk("issue_inst", oInst, e.inst);
                end
            end
        end
    end

    // Memory responder: checks each request against the expected list, holds
    // the address stable, and pulses done LAT cycles after the request appears.
    initial begin
        logic [31:0] cur;
        int          cnt;
        bit          busy;
        cur = '0; cnt = 0; busy = 1'b0;
        forever begin
            @(negedge clk);
            rsp_done = 1'b0;
            if (rsp_pause || rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (oMEM_en !== 1'b1) begin
                    busy = 1'b0;
                    n_vec++;
                    n_err++;
                    $display("FAIL req_dropped: got en 0 want en 1 for %h", cur);
                end else begin
                    chk("req_addr_stable", oMEM_addr, cur);
                    cnt++;
                    if (cnt == LAT) begin
                        rsp_done = 1'b1;
                        rsp_inst = memdata(cur);
                        busy     = 1'b0;
                    end
                end
            end else if (oMEM_en === 1'b1) begin
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_req: got %h want no request", oMEM_addr);
                end else begin
                    chk("req_addr", oMEM_addr, req_q.pop_front());
                end
                cur  = oMEM_addr;
                cnt  = 1;
                busy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h14,
                  32'h100, 32'h0, 32'h100, 32'h0, 32'h4};
        exp_q = '{'{32'h0, 32'h00000013}, '{32'h4, 32'h00040013}, '{32'h8, 32'h00080013},
                  '{32'h0, 32'h00000013}, '{32'h4, 32'h00040013}, '{32'h8, 32'h00080013},
                  '{32'hC, 32'h000C0013},
                  '{32'h0, 32'h00000013}, '{32'h4, 32'h00040013}, '{32'h8, 32'h00080013},
                  '{32'hC, 32'h000C0013}, '{32'h10, 32'h00100013},
                  '{32'h280, 32'h02800013}};

        // Reset state
        tick(3);
        chk("rst_en", {31'b0, oMEM_en}, 32'h0);
        chk("rst_addr", oMEM_addr, 32'h0);
        chk("rst_valid", {31'b0, oInst_valid}, 32'h0);
        chk("rst_inst", oInst, 32'h0);
        chk("rst_pc", oPC, 32'h0);

        // Cold miss at RESET_PC
        rst = 1'b0;
        @(negedge clk);
        k = 0;
        while (oMEM_en === 1'b1 && k < 50) begin
            chk("cold_addr", oMEM_addr, 32'h0);
            k++;
            @(negedge clk);
        end
        chk("cold_hold_cycles", 32'(k), 32'd5);
        chk("cold_valid_T1", {31'b0, oInst_valid}, 32'h0);
        @(negedge clk);
        chk("cold_valid_T2", {31'b0, oInst_valid}, 32'h1);
        chk("cold_inst", oInst, 32'h00000013);
        chk("cold_pc", oPC, 32'h0);

        // Fill 4, 8; redirect to 0 while 0xC is outstanding
        wait_issue(32'h8);
        wait_en(32'hC);
        jump(32'h0);

        // Hit streaming over 0,4,8,C then a miss at 0x10
        wait_issue(32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", {31'b0, oInst_valid}, 32'h1);
            chk("stream_pc", oPC, 32'(4 * i));
        end
        @(negedge clk);
        chk("stream_miss_en", {31'b0, oMEM_en}, 32'h1);
        chk("stream_miss_addr", oMEM_addr, 32'h10);
        chk("stream_miss_valid", {31'b0, oInst_valid}, 32'h0);

        // Redirect to 0x40 two cycles into the 0x10 wait; hold at 0x40 with stall
        tick(1);
        iStall = 1'b1;
        jump(32'h40);
        wait_idle();
        wait_en(32'h40);
        wait_idle();
        tick(2);

        // Stall for 3 cycles during hits
        iStall = 1'b0;
        jump(32'h0);
        wait_issue(32'h0);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, oInst_valid}, 32'h0);
            chk("stall_pc_hold", oPC, 32'h0);
        end
        iStall = 1'b0;
        @(negedge clk);
        chk("stall_resume_valid", {31'b0, oInst_valid}, 32'h1);
        chk("stall_resume_pc", oPC, 32'h4);
        wait_issue(32'h10);
        iStall = 1'b1;
        wait_en(32'h14);
        wait_idle();
        tick(2);

        // Alias eviction at index 0
        jump(32'h100); wait_en(32'h100); wait_idle(); tick(2);
        jump(32'h0);   wait_en(32'h0);   wait_idle(); tick(2);
        jump(32'h100); wait_en(32'h100); wait_idle(); tick(2);

        // rdy low for 4 cycles in WAIT: done and redirect in that window are ignored
        rsp_pause = 1'b1;
        jump(32'h280);
        wait_en(32'h280);
        rdy      = 1'b0;
        frc_done = 1'b1;
        frc_inst = 32'hDEADBEEF;
        iJump_en = 1'b1;
        iJump_pc = 32'h300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frc_done = 1'b0;
            iJump_en = 1'b0;
            chk("frz_en", {31'b0, oMEM_en}, 32'h1);
            chk("frz_addr", oMEM_addr, 32'h280);
            chk("frz_valid", {31'b0, oInst_valid}, 32'h0);
            chk("frz_pc", oPC, 32'h10);
            chk("frz_inst", oInst, 32'h00100013);
        end
        rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_frz_en", {31'b0, oMEM_en}, 32'h1);
        end
        frc_done = 1'b1;
        frc_inst = 32'h02800013;
        @(negedge clk);
        frc_done = 1'b0;
        chk("frz_done_en", {31'b0, oMEM_en}, 32'h0);
        iStall = 1'b0;
        wait_issue(32'h280);
        iStall = 1'b1;

        // Reset mid-WAIT
        wait_en(32'h284);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_en", {31'b0, oMEM_en}, 32'h0);
        chk("rstw_valid", {31'b0, oInst_valid}, 32'h0);
        chk("rstw_pc", oPC, 32'h0);
        rst = 1'b0;
        rsp_pause = 1'b0;
        wait_en(32'h0);
        wait_idle();
        tick(2);
        // 0x4 was cached before reset; it must miss now
        jump(32'h4);
        wait_en(32'h4);
        wait_idle();
        tick(3);

        chk("issues_left", 32'(exp_q.size()), 32'h0);
        chk("reqs_left", 32'(req_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction-side initiator for the memory controller's instruction-fetch port.
- Holds the architectural fetch PC and a direct-mapped instruction cache with one 32-bit word per line.
- Cache hits deliver instructions to the decode/issue stage at up to one per cycle.
- Cache misses issue a word-read request to the memory controller, hold it until the controller signals done, fill the line, then resume lookup.
- Accepts PC redirects from the commit stage (mispredict or jump).

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- ICACHE_IDX_W, 6, index width; the cache has 2^ICACHE_IDX_W lines (default 64).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state freezes.
- oMEM_en  out  1  fetch request to the memory controller; held high until done.
- oMEM_addr  out  32  word-aligned fetch address; stable while oMEM_en is high.
- iMEM_done  in  1  one-cycle pulse; iMEM_inst is valid in the same cycle.
- iMEM_inst  in  32  fetched instruction, little-endian assembled.
- iStall  in  1  downstream queue full; no instruction is issued while high.
- iJump_en  in  1  redirect strobe.
- iJump_pc  in  32  redirect target.
- oInst_valid  out  1  issued-instruction strobe.
- oInst  out  32  issued instruction.
- oPC  out  32  PC of the issued instruction.

Behaviour:
- Reset (clocked, rst=1):
  - pc=RESET_PC.
  - All valid bits cleared.
  - state=LOOKUP.
  - oMEM_en=0, oMEM_addr=0.
  - oInst_valid=0, oInst=0, oPC=0.
  - Reset overrides rdy and aborts any in-flight request; oMEM_en drops in the next cycle.
- rdy=0: pc, state, cache and all outputs hold their values. Redirect strobes arriving while rdy=0 are ignored.
- Address split: index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2]; pc[1:0] is ignored (always 0).
- Per-line storage: valid bit, tag, and 32-bit data word. Lookup is combinational on pc; all outputs are registered.
- State LOOKUP, evaluated in priority order:
  - iJump_en: pc<=iJump_pc, oInst_valid<=0. A redirect beats a simultaneous hit.
  - else hit and !iStall: oInst_valid<=1, oInst<=line data, oPC<=pc, pc<=pc+4 (32-bit wrap).
  - else hit and iStall: oInst_valid<=0, pc holds.
  - else miss: oInst_valid<=0, oMEM_en<=1, oMEM_addr<=pc, state<=WAIT.
  - iStall does not block miss requests (prefetch of the current PC).
- State WAIT:
  - oMEM_en and oMEM_addr stay stable; oInst_valid=0.
  - iJump_en: pc<=iJump_pc. The outstanding request is not aborted.
  - iMEM_done: write the line at oMEM_addr's index with {valid=1, tag of oMEM_addr, iMEM_inst}; oMEM_en<=0; state<=LOOKUP.
  - The fill always uses the latched oMEM_addr, never pc, so data fetched before a redirect is still cached correctly.
  - Redirect and done in the same cycle: both take effect.
- Latency:
  - Hit: pc to oInst_valid is 1 cycle.
  - Miss: the first LOOKUP cycle after done re-reads the now-valid line, so oInst_valid follows 1 cycle after that (done+2).
  - The memory controller needs at least 5 cycles from request to done, and more if data-side traffic has priority.
- Handshake: oMEM_en is deasserted in the cycle after done, so the controller returns to idle and does not re-issue the request. The fetcher never drops oMEM_en before done.
- Conflict: two PCs with equal index and different tags evict each other; a replacement overwrites unconditionally.
- oInst and oPC hold their last issued values when oInst_valid=0.

Test Plan:
- Cold miss after reset: RESET_PC=0; model returns done with 0x00000013 five cycles after oMEM_en.
  - Required: oMEM_en=1 and oMEM_addr=0 from cycle 1 until the done cycle T.
  - oMEM_en=0 at T+1.
  - oInst_valid=1, oInst=0x13, oPC=0 at T+2.
- Hit streaming: pre-filled lines at 0x0, 0x4, 0x8, iStall=0.
  - Required: three consecutive cycles with oInst_valid and oPC=0,4,8.
  - Then a miss at 0xC with oMEM_addr=0xC.
- Stall: iStall=1 for 3 cycles during hits.
  - Required: no oInst_valid while stalled; pc holds.
  - After release, the next oPC is the next sequential PC with no gap or duplicate.
- Redirect during WAIT: miss on 0x10; iJump_en with iJump_pc=0x40 two cycles later.
  - Required: oMEM_addr stays 0x10 until done; the 0x10 line is filled.
  - The next request or hit is at 0x40; 0x10 is never issued.
- Alias eviction (64 lines): fetch 0x000, then jump to 0x100, then jump back to 0x000.
  - Required: three misses with oMEM_addr=0x000, 0x100, 0x000.
- rdy low and reset mid-WAIT:
  - rdy=0 for 4 cycles in WAIT: all outputs frozen, and a done pulse in that window is ignored.
  - rst during WAIT: oMEM_en=0, oInst_valid=0 the next cycle, and the next request is at RESET_PC as a miss.
